scariv_credit_return_slave: RTL



---
 rtl/scariv_credit_return_slave_pkg.sv | 14 +
 rtl/scariv_credit_return_slave.sv | 135 +++++++++++++
 2 files changed

// File: rtl/scariv_credit_return_slave_pkg.sv
// Shared types and helpers for the credit-return slave.
package scariv_credit_return_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } cre_ret_state_t;

    function automatic int min_credit(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/scariv_credit_return_slave.sv
// Collects freed entries and returns them as capped credit beats to the dispatch master.
// Optional SCARIV_CREDIT_RET_CHECK_EN adds a sticky o_overflow flag and runtime assertions.
//
// state | meaning
// IDLE  | no beat in the output register
// SEND  | beat valid, last cycle loaded or fired
// STALL | beat valid and held because the master withheld ready
module scariv_credit_return_slave
    import scariv_credit_return_slave_pkg::*;
#(
    parameter int MAX_CREDITS = 8,
    parameter int MAXIMAL_VAL = 2,
    parameter int RETURN_MAX  = 4,
    parameter int STALL_LIMIT = 16
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_free_valid,
    input  logic [$clog2(MAXIMAL_VAL+1)-1:0]   i_free_val,
    output logic                               o_cre_ret_valid,
    output logic [$clog2(RETURN_MAX+1)-1:0]    o_cre_ret_val,
    input  logic                               i_cre_ret_ready,
    output logic [$clog2(MAX_CREDITS+1)-1:0]   o_pending,
    output logic                               o_stall_err
`ifdef SCARIV_CREDIT_RET_CHECK_EN
    ,
    output logic                               o_overflow
`endif
);

    localparam int PW = $clog2(MAX_CREDITS+1);
    localparam int FW = $clog2(MAXIMAL_VAL+1);
    localparam int RW = $clog2(RETURN_MAX+1);
    localparam int AW = ((PW > FW) ? PW : FW) + 1;
    localparam int SW = $clog2(STALL_LIMIT+1);

    cre_ret_state_t state, state_nxt;

    logic [PW-1:0] r_pending;
    logic [RW-1:0] r_val;
    logic [SW-1:0] r_stall_cnt;
    logic          r_stall_err;

    logic [AW-1:0] free_in;
    logic [AW-1:0] avail;
    logic [AW-1:0] beat_amt;
    logic [AW-1:0] clamp_amt;
    logic          loadable;
    logic          stalled;
    logic [PW-1:0] pending_nxt;
    logic [RW-1:0] val_nxt;
    logic [SW-1:0] stall_cnt_nxt;

    // Valid is encoded in the FSM: any non-IDLE state holds a live beat.
    assign o_cre_ret_valid = (state != IDLE);
    assign o_cre_ret_val   = r_val;
    assign o_pending       = r_pending;
    assign o_stall_err     = r_stall_err;

    always_comb begin
        free_in   = i_free_valid ? AW'(i_free_val) : '0;
        avail     = AW'(r_pending) + free_in;
        beat_amt  = AW'(min_credit(int'(avail), RETURN_MAX));
        clamp_amt = AW'(min_credit(int'(avail), MAX_CREDITS));
        loadable  = (state == IDLE) || i_cre_ret_ready;
        stalled   = (state != IDLE) && !i_cre_ret_ready;
    end

    always_comb begin
        state_nxt     = state;
        pending_nxt   = r_pending;
        val_nxt       = r_val;
        stall_cnt_nxt = '0;
        if (loadable) begin
            // A beat firing this cycle is already accounted for; avail is what is left.
            pending_nxt = PW'(avail - beat_amt);
            if (avail != '0) begin
                val_nxt   = RW'(beat_amt);
                state_nxt = SEND;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            pending_nxt = PW'(clamp_amt);
            state_nxt   = STALL;
        end
        if (stalled) begin
            stall_cnt_nxt = (r_stall_cnt == SW'(STALL_LIMIT)) ? r_stall_cnt : r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending   <= '0;
            r_val       <= '0;
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_pending   <= pending_nxt;
            r_val       <= val_nxt;
            r_stall_cnt <= stall_cnt_nxt;
            r_stall_err <= r_stall_err | (stall_cnt_nxt == SW'(STALL_LIMIT));
        end
    end

`ifdef SCARIV_CREDIT_RET_CHECK_EN
    logic r_overflow;
    assign o_overflow = r_overflow;

    // More credits than entries means the upstream freed something twice.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow | (avail > AW'(MAX_CREDITS));
        end
    end

    a_free_range: assert property (@(posedge i_clk) disable iff (i_reset)
        free_in <= AW'(MAXIMAL_VAL));
    a_hold_stable: assert property (@(posedge i_clk) disable iff (i_reset)
        (o_cre_ret_valid && !i_cre_ret_ready) |=> $stable(o_cre_ret_val));
    a_nonzero_beat: assert property (@(posedge i_clk) disable iff (i_reset)
        o_cre_ret_valid |-> (o_cre_ret_val != '0));
`endif

endmodule
